axi_apb_rd_bridge_p: RTL
========================

Name: axi_apb_rd_bridge_p

Overview:
Parametrised AXI-read to APB bridge, next generation of the single-width, four-slave read bridge. Accepts one AR burst (FIXED/INCR/WRAP, up to 16 beats), converts each beat into an APB read to one of NSLV slaves, and buffers returned data in an R-channel FIFO so that rready back-pressure throttles APB traffic. Maps PSLVERR and undecoded addresses onto rresp. Sits between the AXI read master and the APB peripheral slaves.

Parameters:
DATA_W, 16, width of rdata/PRDATA
ADDR_W, 5, width of araddr (word address)
SLV_ADDR_W, 3, low araddr bits driven on PADDR; the upper ADDR_W-SLV_ADDR_W bits select the slave
NSLV, 4, number of APB slaves, 1..2^(ADDR_W-SLV_ADDR_W)
FIFO_DEPTH, 4, R-buffer entries, power of two, >=2

Ports:
clk  in  1  clock, rising edge
res_n  in  1  asynchronous active-low reset
arvalid  in  1  AR valid
arready  out  1  AR ready
araddr  in  ADDR_W  burst start word address
arlen  in  4  beats minus 1
arburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 treated as INCR
rvalid  out  1  R valid
rready  in  1  R ready
rdata  out  DATA_W  read data
rresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
rlast  out  1  last beat of burst
PADDR  out  SLV_ADDR_W  APB address
PSEL  out  NSLV  one-hot slave select
PENABLE  out  1  APB enable
PWRITE  out  1  tied 0
PRDATA  in  DATA_W  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB error

Behaviour:
- Reset (async, res_n=0): FSM to IDLE; FIFO flushed; arready, rvalid, rlast, PSEL, PENABLE, PWRITE, PADDR, rdata, rresp all 0. Takes effect immediately, including mid-burst; the burst is discarded and no beats are replayed.
- arready is registered. It is set on the first clock edge after reset release and whenever the FSM is IDLE. It is cleared on the edge where arvalid&&arready. Only one burst is in flight at a time.
- FSM states: IDLE, WAIT_SPACE, SETUP, ACCESS.
  - IDLE -> handshake: latch addr/len/burst, beat count=0, go to SETUP if FIFO count<FIFO_DEPTH, else WAIT_SPACE.
  - WAIT_SPACE -> SETUP once count<FIFO_DEPTH.
  - SETUP: PSEL[idx]=1, PENABLE=0, PADDR=addr[SLV_ADDR_W-1:0]; next cycle go to ACCESS.
  - ACCESS: PSEL and PENABLE held, PADDR stable. Stays in ACCESS while PREADY=0 (no timeout).
  - On the edge where PREADY=1: push {PRDATA, resp, last} into the FIFO and drop PENABLE. If more beats remain, advance the address and go to SETUP if space, else WAIT_SPACE (PSEL low). On the last beat, go to IDLE with arready=1.
- Space is checked before SETUP. At most one APB transfer is outstanding, so a push never overflows the FIFO.
- Decode: idx=addr[ADDR_W-1:SLV_ADDR_W]. If idx>=NSLV there is no APB transfer: SETUP/ACCESS are skipped, a beat with rdata=0 and rresp=11 is pushed one cycle after entry (space permitting), and the burst continues.
- Per-beat rresp: 11 if undecoded; else 10 if PSLVERR was sampled with PREADY; else 00. An error does not abort the burst.
- Address advance, modulo 2^ADDR_W:
  - FIXED: unchanged.
  - INCR: +1, wraps from 2^ADDR_W-1 to 0.
  - WRAP: valid for arlen 1, 3, 7 or 15. The low log2(arlen+1) bits increment modulo arlen+1 and the upper bits are held. Any other arlen behaves as INCR.
- rlast is set on beat arlen only.
- R channel:
  - rvalid = FIFO not empty; rdata/rresp/rlast come from the head entry, registered.
  - A beat pushed at edge E is visible (rvalid=1) immediately after E.
  - Pop on rvalid&&rready.
  - Simultaneous push and pop when full cannot occur, because push requires prior space. Simultaneous push and pop when count=1 keeps rvalid=1 and shows the new entry next cycle.
- A new AR may be accepted while earlier beats are still in the FIFO; ordering is preserved.

Test Plan:
1. INCR, araddr=9, arlen=3, PREADY=1, PRDATA 10,17,25,30, rready=0 -> PSEL=0010; PADDR 1,2,3,4; each transfer is one SETUP cycle plus one ACCESS cycle; FIFO fills to 4. Then rready=1 -> rdata 10,17,25,30, rresp=00, rlast only with 30; arready=1 after the 4th ACCESS.
2. WRAP, araddr=6, arlen=3 -> PADDR sequence 6,7,4,5 on PSEL=0001. Then FIXED, araddr=2, arlen=2 -> PADDR 2,2,2.
3. INCR, arlen=15, rready=0, FIFO_DEPTH=4 -> exactly 4 APB transfers, then the FSM holds in WAIT_SPACE with PSEL=0. Pulse rready for one beat -> one more transfer. Full drain with rready=1 returns 16 beats, rlast on the 16th.
4. PREADY low for 3 ACCESS cycles on beat 1 and PSLVERR=1 on beat 2 -> PENABLE is held 4 cycles on beat 1; rresp is 00,10,00,00; all 4 beats are returned.
5. NSLV=3, araddr=25 (idx 3), arlen=1 -> PSEL stays 0; two beats returned with rdata=0, rresp=11, rlast on the second.
6. Assert res_n=0 during ACCESS of beat 2, with 1 beat already in the FIFO -> PSEL, PENABLE and rvalid drop with no clock edge needed; after release arready=1 and a new burst runs cleanly with no stale beats.

Source files
------------

// File: rtl/axi_apb_rd_bridge_p.sv
// AXI read-burst to APB bridge: one AR burst at a time, one APB read per beat,
// returned beats buffered in an R FIFO so rready back-pressure throttles APB.
module axi_apb_rd_bridge_p #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 5,
    parameter int SLV_ADDR_W = 3,
    parameter int NSLV       = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  res_n,
    input  logic                  arvalid,
    output logic                  arready,
    input  logic [ADDR_W-1:0]     araddr,
    input  logic [3:0]            arlen,
    input  logic [1:0]            arburst,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [DATA_W-1:0]     rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic [SLV_ADDR_W-1:0] PADDR,
    output logic [NSLV-1:0]       PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    input  logic [DATA_W-1:0]     PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam int IDX_W = ADDR_W - SLV_ADDR_W;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W = DATA_W + 3;
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT_SPACE, SETUP, ACCESS} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d, addr_nxt, wrap_mask;
    logic [3:0]         len_q, len_d, beat_q, beat_d;
    logic [1:0]         burst_q, burst_d;
    logic               arready_q, arready_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d, count_after;
    logic [ENT_W-1:0]   mem_q [FIFO_DEPTH];
    logic [ENT_W-1:0]   push_entry, head;
    logic [IDX_W-1:0]   idx;
    logic [NSLV-1:0]    sel_onehot;
    logic               push, pop, space, decoded, last_beat, wrap_ok;

    assign idx         = addr_q[ADDR_W-1:SLV_ADDR_W];
    assign decoded     = ({1'b0, idx} < (IDX_W+1)'(NSLV));
    assign sel_onehot  = NSLV'(1) << idx;
    assign last_beat   = (beat_q == len_q);
    assign space       = (count_q < CNT_FULL);
    assign rvalid      = (count_q != '0);
    assign pop         = rvalid && rready;
    // FIFO fill level after the beat being pushed this cycle, net of any pop
    assign count_after = count_q + CNT_W'(1) - CNT_W'(pop);

    assign wrap_ok   = (burst_q == 2'b10) &&
                       (len_q == 4'd1 || len_q == 4'd3 || len_q == 4'd7 || len_q == 4'd15);
    assign wrap_mask = ADDR_W'(len_q);

    always_comb begin
        addr_nxt = addr_q + ADDR_ONE;
        if (burst_q == 2'b00) begin
            addr_nxt = addr_q;
        end else if (wrap_ok) begin
            addr_nxt = (addr_q & ~wrap_mask) | ((addr_q + ADDR_ONE) & wrap_mask);
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        burst_d    = burst_q;
        beat_d     = beat_q;
        push       = 1'b0;
        push_entry = '0;
        case (state_q)
            IDLE: begin
                if (arvalid && arready_q) begin
                    addr_d  = araddr;
                    len_d   = arlen;
                    burst_d = arburst;
                    beat_d  = '0;
                    state_d = space ? SETUP : WAIT_SPACE;
                end
            end
            WAIT_SPACE: begin
                if (space) state_d = SETUP;
            end
            SETUP: begin
                if (decoded) begin
                    state_d = ACCESS;
                end else begin
                    push       = 1'b1;
                    push_entry = {{DATA_W{1'b0}}, 2'b11, last_beat};
                end
            end
            ACCESS: begin
                if (PREADY) begin
                    push       = 1'b1;
                    push_entry = {PRDATA, (PSLVERR ? 2'b10 : 2'b00), last_beat};
                end
            end
            default: state_d = IDLE;
        endcase
        if (push) begin
            if (last_beat) begin
                state_d = IDLE;
            end else begin
                addr_d  = addr_nxt;
                beat_d  = beat_q + 4'd1;
                state_d = (count_after < CNT_FULL) ? SETUP : WAIT_SPACE;
            end
        end
        arready_d = (state_d == IDLE);
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            burst_q   <= '0;
            beat_q    <= '0;
            arready_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            burst_q   <= burst_d;
            beat_q    <= beat_d;
            arready_q <= arready_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // Storage needs no reset: outputs are gated by rvalid, so stale entries never show
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_entry;
    end

    assign head    = mem_q[rd_ptr_q];
    assign rdata   = rvalid ? head[ENT_W-1:3] : '0;
    assign rresp   = rvalid ? head[2:1] : 2'b00;
    assign rlast   = rvalid ? head[0] : 1'b0;
    assign arready = arready_q;
    assign PSEL    = ((state_q == SETUP || state_q == ACCESS) && decoded) ? sel_onehot : '0;
    assign PENABLE = (state_q == ACCESS);
    assign PADDR   = addr_q[SLV_ADDR_W-1:0];
    assign PWRITE  = 1'b0;

endmodule
